// File: rtl/tlb_walk_controller.sv
// TLB miss/walk/fill controller: steers array address and strobes, drives the
// page-table walker handshake, handles deferred flush, faults and miss counting.
module tlb_walk_controller #(
  parameter int size    = 16,
  parameter int tagbits = 20,
  parameter int cntbits = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     Req,
  input  logic [tagbits-1:0]       VirtTag,
  input  logic                     Hit,
  input  logic [$clog2(size)-1:0]  HitIdx,
  input  logic                     WalkDone,
  input  logic                     WalkFault,
  input  logic                     Flush,
  output logic [$clog2(size)-1:0]  CAdr,
  output logic                     CRead,
  output logic                     CWrite,
  output logic                     WalkReq,
  output logic [tagbits-1:0]       WalkTag,
  output logic                     FlushAll,
  output logic                     PAReady,
  output logic                     Fault,
  output logic [cntbits-1:0]       MissCount
);

  localparam int iw = $clog2(size);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WALK  = 2'd1,
    FILL  = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t             state, state_d;
  logic [iw-1:0]      victim, victim_d;
  logic [cntbits-1:0] misscnt, misscnt_d;
  logic [tagbits-1:0] walktag, walktag_d;
  logic               pend, pend_d;
  logic               flushall_q, flushall_d;

  function automatic logic [cntbits-1:0] sat_inc(input logic [cntbits-1:0] v);
    return (&v) ? v : v + cntbits'(1);
  endfunction

  // Round-robin wrap that works for any depth, not just powers of two.
  function automatic logic [iw-1:0] ptr_next(input logic [iw-1:0] p);
    return (p == iw'(size - 1)) ? '0 : p + iw'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      victim     <= '0;
      misscnt    <= '0;
      walktag    <= '0;
      pend       <= 1'b0;
      flushall_q <= 1'b0;
    end else begin
      state      <= state_d;
      victim     <= victim_d;
      misscnt    <= misscnt_d;
      walktag    <= walktag_d;
      pend       <= pend_d;
      flushall_q <= flushall_d;
    end
  end

  always_comb begin
    state_d    = state;
    victim_d   = victim;
    misscnt_d  = misscnt;
    walktag_d  = walktag;
    pend_d     = pend;
    flushall_d = 1'b0;
    CAdr       = victim;
    CRead      = 1'b0;
    CWrite     = 1'b0;
    WalkReq    = 1'b0;
    PAReady    = 1'b0;
    Fault      = 1'b0;

    if (!enable) begin
      PAReady = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (Req) begin
            CRead = 1'b1;
            if (Hit) begin
              CAdr    = HitIdx;
              PAReady = 1'b1;
            end else begin
              walktag_d = VirtTag;
              misscnt_d = sat_inc(misscnt);
              state_d   = WALK;
            end
          end
        end
        WALK: begin
          WalkReq = 1'b1;
          if (WalkDone) state_d = WalkFault ? FAULT : FILL;
        end
        FILL: begin
          CWrite   = 1'b1;
          victim_d = ptr_next(victim);
          state_d  = IDLE;
        end
        FAULT: begin
          Fault   = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    // Flush outside IDLE is parked and released on the return to IDLE, so an
    // in-flight fill still lands and is then wiped by the single FlushAll.
    if (state == IDLE) begin
      if (Flush) begin
        flushall_d = 1'b1;
        victim_d   = '0;
      end
    end else if (state_d == IDLE) begin
      if (Flush || pend) begin
        flushall_d = 1'b1;
        victim_d   = '0;
      end
      pend_d = 1'b0;
    end else if (Flush) begin
      pend_d = 1'b1;
    end
  end

  assign FlushAll  = flushall_q;
  assign WalkTag   = walktag;
  assign MissCount = misscnt;

endmodule
